// File: rtl/decompressor_feeder.sv
// decompressor_feeder: turns an upstream control-word/item stream into
// paced single-item issues for decompressor_top, with progress and error status.
module decompressor_feeder #(
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 1024,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [15:0]            dec_data_in,
  output logic                   dec_control_word_in,
  output logic                   dec_data_in_valid,
  input  logic                   dec_busy,
  output logic [COUNT_WIDTH-1:0] items_issued,
  output logic                   done,
  output logic                   error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CW,
    ST_GET_ITEM,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam int BW =
    (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam bit TO_ON = (BUSY_TIMEOUT != 0);
  localparam logic [BW-1:0] BLIM =
    BW'((BUSY_TIMEOUT > 0) ? BUSY_TIMEOUT - 1 : 0);
  localparam logic [3:0] GLIM = 4'(GAP_CYCLES);

  state_t        state;
  logic [7:0]    cw;
  logic [2:0]    k;
  logic          last;
  logic [3:0]    gap;
  logic [BW-1:0] bcnt;

  logic hs;
  assign hs = s_valid & s_ready;

  // Sequencer: all state and outputs are registered here.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state               <= ST_IDLE;
      cw                  <= '0;
      k                   <= '0;
      last                <= 1'b0;
      gap                 <= '0;
      bcnt                <= '0;
      s_ready             <= 1'b0;
      dec_data_in         <= '0;
      dec_control_word_in <= 1'b0;
      dec_data_in_valid   <= 1'b0;
      items_issued        <= '0;
      done                <= 1'b0;
      error               <= 1'b0;
    end else if (start && state != ST_IDLE
                 && state != ST_DONE) begin
      // A start in mid-stream means upstream lost track: stop hard.
      state               <= ST_ERROR;
      error               <= 1'b1;
      s_ready             <= 1'b0;
      dec_data_in         <= '0;
      dec_control_word_in <= 1'b0;
      dec_data_in_valid   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_GET_CW;
            done         <= 1'b0;
            items_issued <= '0;
            s_ready      <= 1'b1;
          end
        end
        ST_GET_CW: begin
          if (hs) begin
            cw <= s_data[7:0];
            k  <= '0;
            if (s_last) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              s_ready <= 1'b0;
            end else begin
              state <= ST_GET_ITEM;
            end
          end
        end
        ST_GET_ITEM: begin
          if (hs) begin
            dec_data_in         <= s_data;
            last                <= s_last;
            dec_control_word_in <= cw[3'd7 - k];
            dec_data_in_valid   <= 1'b1;
            s_ready             <= 1'b0;
            state               <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!dec_busy) begin
            if (items_issued != '1)
              items_issued <= items_issued + 1'b1;
            dec_data_in_valid <= 1'b0;
            gap               <= 4'd1;
            bcnt              <= '0;
            state             <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (gap < GLIM)
            gap <= gap + 4'd1;
          if (dec_busy) begin
            if (TO_ON && bcnt == BLIM) begin
              state               <= ST_ERROR;
              error               <= 1'b1;
              dec_data_in         <= '0;
              dec_control_word_in <= 1'b0;
            end else if (TO_ON) begin
              bcnt <= bcnt + 1'b1;
            end
          end else begin
            bcnt <= '0;
            if (gap >= GLIM) begin
              if (last) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end else if (k == 3'd7) begin
                state   <= ST_GET_CW;
                s_ready <= 1'b1;
              end else begin
                k       <= k + 3'd1;
                state   <= ST_GET_ITEM;
                s_ready <= 1'b1;
              end
            end
          end
        end
        ST_ERROR: begin
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decompressor_feeder.sv
// tb_decompressor_feeder: directed streams against a queue model of
// the expected issue sequence, checked every cycle from one monitor.
module tb_decompressor_feeder;

  localparam int GAP = 2;
  localparam int TO  = 16;
  localparam int CNW = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [15:0]    s_data = '0;
  logic           s_valid = 1'b0;
  logic           s_last = 1'b0;
  logic           s_ready;
  logic [15:0]    dec_data_in;
  logic           dec_control_word_in;
  logic           dec_data_in_valid;
  logic           dec_busy = 1'b0;
  logic [CNW-1:0] items_issued;
  logic           done;
  logic           error;

  decompressor_feeder #(
    .GAP_CYCLES(GAP),
    .BUSY_TIMEOUT(TO),
    .COUNT_WIDTH(CNW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_last(s_last),
    .s_ready(s_ready),
    .dec_data_in(dec_data_in),
    .dec_control_word_in(dec_control_word_in),
    .dec_data_in_valid(dec_data_in_valid),
    .dec_busy(dec_busy),
    .items_issued(items_issued),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic        c;
  } exp_t;

  exp_t        q[$];
  int          model_cnt = 0;
  logic        pv = 1'b0;
  logic [15:0] pd = '0;
  logic        pc = 1'b0;
  int          low_run = 0;
  bit          seen = 0;
  int          hi_run = 0;
  int          hi_last = 0;
  logic [7:0]  ctrl_hist = '0;
  int          n_acc = 0;

  // Monitor: sampled mid-cycle, so values are those the next edge sees.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      q.delete();
      model_cnt = 0;
      seen      = 0;
      pv        = 1'b0;
      low_run   = 0;
      hi_run    = 0;
    end else begin
      check("items_issued", 32'(items_issued), 32'(model_cnt));
      check("ready_with_valid",
            32'(s_ready & dec_data_in_valid), 0);
      if (error)
        check("error_outputs",
              32'({dec_data_in, dec_control_word_in,
                   dec_data_in_valid}), 0);
      if (dec_data_in_valid) begin
        hi_run++;
        if (pv)
          check("hold_stable",
                32'({dec_data_in, dec_control_word_in}),
                32'({pd, pc}));
        else if (seen)
          check("gap_min", 32'(low_run >= GAP), 1);
        if (!dec_busy) begin
          if (q.size() == 0) begin
            check("unexpected_issue", 1, 0);
          end else begin
            e = q.pop_front();
            check("issue_data", 32'(dec_data_in), 32'(e.d));
            check("issue_ctrl", 32'(dec_control_word_in),
                  32'(e.c));
          end
          if (model_cnt < 65535) model_cnt++;
          ctrl_hist = {ctrl_hist[6:0], dec_control_word_in};
          n_acc++;
          hi_last = hi_run;
          hi_run  = 0;
          low_run = 0;
          seen    = 1;
        end
      end else begin
        low_run++;
        hi_run = 0;
      end
      pv = dec_data_in_valid;
      pd = dec_data_in;
      pc = dec_control_word_in;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int t;
    t = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    do begin
      @(negedge clock);
      t++;
    end while (!s_ready && t < 300);
    check("beat_taken", 32'(s_ready), 1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] d, input logic c);
    exp_t e;
    e.d = d;
    e.c = c;
    q.push_back(e);
  endtask

  task automatic send_group(input logic [7:0] cwv, input int n,
                            input logic [15:0] base,
                            input logic last_grp);
    send_beat({8'h00, cwv}, last_grp && n == 0);
    for (int j = 0; j < n; j++) begin
      push_exp(base + 16'(j), cwv[7-j]);
      send_beat(base + 16'(j), last_grp && j == n - 1);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start     = 1'b0;
    model_cnt = 0;
    n_acc     = 0;
    ctrl_hist = '0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 1000) begin
      @(negedge clock);
      t++;
    end
    check("done_reached", 32'(done), 1);
    tick();
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!dec_data_in_valid && t < 100);
    check("valid_seen", 32'(dec_data_in_valid), 1);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_s_ready"}, 32'(s_ready), 0);
    check({nm, "_data"}, 32'(dec_data_in), 0);
    check({nm, "_ctrl"}, 32'(dec_control_word_in), 0);
    check({nm, "_valid"}, 32'(dec_data_in_valid), 0);
    check({nm, "_items"}, 32'(items_issued), 0);
    check({nm, "_done"}, 32'(done), 0);
    check({nm, "_error"}, 32'(error), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Power-on reset.
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check_reset_vals("por");
    reset = 1'b1;
    tick();

    // One full group, cw=A5, items 1..8.
    do_start();
    send_group(8'hA5, 8, 16'h0001, 1'b1);
    wait_done();
    check("g1_items", 32'(items_issued), 8);
    check("g1_ctrl_bits", 32'(ctrl_hist), 32'h A5);
    check("g1_issues", 32'(n_acc), 8);

    // Full group of ones, then a one-item final group.
    do_start();
    send_group(8'hFF, 8, 16'h0100, 1'b0);
    send_group(8'h80, 1, 16'h1234, 1'b1);
    wait_done();
    check("g2_items", 32'(items_issued), 9);
    check("g2_last_ctrl", 32'(ctrl_hist[0]), 1);
    check("g2_ctrl_bits", 32'(ctrl_hist), 32'h FF);

    // Decompressor busy for the first five ISSUE cycles.
    do_start();
    send_beat(16'h0080, 1'b0);
    dec_busy = 1'b1;
    push_exp(16'hBEEF, 1'b1);
    send_beat(16'hBEEF, 1'b1);
    wait_valid();
    repeat (4) @(posedge clock);
    @(posedge clock);
    #1;
    dec_busy = 1'b0;
    wait_done();
    check("bp_items", 32'(items_issued), 1);
    check("bp_hold_len", 32'(hi_last), 6);

    // Reset while an item is being offered.
    do_start();
    send_beat(16'h0080, 1'b0);
    dec_busy = 1'b1;
    push_exp(16'h4321, 1'b1);
    send_beat(16'h4321, 1'b1);
    wait_valid();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check_reset_vals("mid_rst");
    tick();
    reset    = 1'b1;
    dec_busy = 1'b0;
    tick();
    @(negedge clock);
    check("post_rst_ready", 32'(s_ready), 0);
    check("post_rst_valid", 32'(dec_data_in_valid), 0);
    tick();
    do_start();
    send_group(8'h5A, 3, 16'h0A00, 1'b1);
    wait_done();
    check("rr_items", 32'(items_issued), 3);
    check("rr_ctrl_bits", 32'(ctrl_hist[2:0]), 32'b010);

    // Empty stream, then start in mid-stream.
    do_start();
    send_beat(16'h00C3, 1'b1);
    wait_done();
    check("empty_done", 32'(done), 1);
    check("empty_items", 32'(items_issued), 0);
    do_start();
    send_beat(16'h00C3, 1'b0);
    @(negedge clock);
    check("pe_in_get_item", 32'(s_ready), 1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clock);
    check("pe_error", 32'(error), 1);
    check("pe_ready", 32'(s_ready), 0);
    check("pe_done", 32'(done), 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("pe_cleared", 32'(error), 0);
    tick();

    // Busy stuck high after the first acceptance.
    do_start();
    send_beat(16'h0000, 1'b0);
    push_exp(16'h7777, 1'b0);
    send_beat(16'h7777, 1'b0);
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!(dec_data_in_valid && !dec_busy) && t < 100);
    check("to_accept", 32'(dec_data_in_valid && !dec_busy), 1);
    @(posedge clock);
    #1;
    dec_busy = 1'b1;
    repeat (16) @(negedge clock);
    check("to_not_yet", 32'(error), 0);
    @(negedge clock);
    check("to_error", 32'(error), 1);
    check("to_valid", 32'(dec_data_in_valid), 0);
    check("to_data", 32'(dec_data_in), 0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("to_sticky", 32'(error), 1);
    check("to_valid_after", 32'(dec_data_in_valid), 0);
    reset = 1'b0;
    repeat (2) tick();
    reset    = 1'b1;
    dec_busy = 1'b0;
    tick();
    @(negedge clock);
    check("to_cleared", 32'(error), 0);
    check("to_items_clr", 32'(items_issued), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
